pixel_line_bank_ctrl: RTL
=========================

// Module: pixel_line_bank_ctrl
//
// PURPOSE
//   Ping-pong line scheduler for the dual-port pixel RAM. The RAM is split into two
//   line banks, and the address MSB selects the bank. LCD-side pixels fill one bank
//   while the LED scanner drains the other. Banks hand over whole lines, so the LED
//   side never reads a partially written line. Sits between the LCD capture logic,
//   the pixel RAM (write port A, registered read port B) and the LED row driver.
//
// PARAMETERS
//   DATA_WIDTH   24   pixel width (RGB888)
//   ADDR_WIDTH   9    pixel RAM address width; MSB = bank select
//   LINE_PIXELS  256  pixels per line; 2 <= LINE_PIXELS <= 2**(ADDR_WIDTH-1)
//   CNT_WIDTH    8    width of the overrun counter
//
// PORTS
//   clk              in   1           single clock (RAM clk_a and clk_b tie to clk)
//   reset_n          in   1           asynchronous, active-low reset
//   lcd_line_start   in   1           pulse: first pixel of a new LCD line follows
//   lcd_valid        in   1           LCD pixel present on lcd_data
//   lcd_data         in   DATA_WIDTH  LCD pixel
//   lcd_ready        out  1           write bank has room
//   led_line_ready   out  1           a complete line is available to read
//   led_rd_en        in   1           request the next pixel of the ready line
//   led_valid        out  1           led_data valid (1 cycle after accepted led_rd_en)
//   led_data         out  DATA_WIDTH  pixel = ram_q_b
//   overrun_count    out  CNT_WIDTH   saturating count of dropped LCD pixels
//   ram_we_a         out  1           pixel RAM write enable
//   ram_addr_a       out  ADDR_WIDTH  {wr_bank, wr_ptr}
//   ram_data_a       out  DATA_WIDTH  = lcd_data
//   ram_addr_b       out  ADDR_WIDTH  {rd_bank, rd_ptr}
//   ram_q_b          in   DATA_WIDTH  pixel RAM registered read data
//
// BEHAVIOUR
//   State: wr_bank, rd_bank (1 bit each); wr_ptr, rd_ptr (ADDR_WIDTH-1 bits each);
//     full[1:0] (one flag per bank).
//   Reset (async, reset_n=0): all state = 0, led_valid = 0, overrun_count = 0.
//     Result: lcd_ready = 1, led_line_ready = 0.
//   lcd_ready = !full[wr_bank].
//   Write accept: wr_acc = lcd_valid & lcd_ready.
//     ram_we_a = wr_acc (combinational). The RAM write lands at the same edge.
//   Write pointer:
//     - wr_acc increments wr_ptr.
//     - On the accept with wr_ptr == LINE_PIXELS-1: wr_ptr -> 0, full[wr_bank] -> 1,
//       wr_bank toggles.
//   lcd_line_start resync:
//     - Forces wr_ptr to 0 before the same-cycle accept is applied. A pixel accepted
//       in that cycle is written at address 0 and wr_ptr -> 1.
//     - A partial line is discarded in place. full is unaffected.
//   Drop: lcd_valid & !lcd_ready -> pixel dropped, no write, overrun_count
//     increments and saturates at all-ones. The pointer does not move.
//   led_line_ready = full[rd_bank].
//   Read accept: rd_acc = led_rd_en & led_line_ready.
//     - led_rd_en while the line is not ready is ignored.
//     - ram_addr_b = {rd_bank, rd_ptr} combinational.
//     - led_valid <= rd_acc (registered), led_data = ram_q_b, so latency is 1 cycle.
//     - Back-to-back reads give 1 pixel per cycle.
//   Read pointer:
//     - rd_acc increments rd_ptr.
//     - On the accept with rd_ptr == LINE_PIXELS-1: rd_ptr -> 0, full[rd_bank] -> 0,
//       rd_bank toggles. led_valid for that last pixel still asserts next cycle.
//   Simultaneous last-write and last-read in one cycle:
//     - They always target different banks. Both flag updates apply independently.
//     - The full vector is updated per-bit, never overwritten whole.
//   Both banks full: lcd_ready = 0 until the reader finishes a line.
//     The freed bank is writable the cycle after its last read.
//   Reset mid-line: all partial progress is lost and both banks are treated as empty.
//     RAM contents are don't-care.
//   No combinational path from led_rd_en to lcd_ready or from lcd_valid to
//     led_line_ready.
//
// TESTING
//   1. Reset, then 256 consecutive lcd_valid pixels 0..255 -> bank 0 full,
//      led_line_ready=1 the cycle after the last write. ram_addr_a ran 0x000..0x0FF.
//   2. Hold led_rd_en 256 cycles -> led_valid 256 cycles delayed by 1, led_data =
//      0..255, ram_addr_b 0x000..0x0FF, then led_line_ready=0.
//   3. Write 512 pixels with no reads -> lcd_ready drops after pixel 511. 10 further
//      lcd_valid cycles -> overrun_count=10 and no ram_we_a. Read one line, then
//      lcd_ready=1 and the next write goes to address 0x000.
//   4. Write 100 pixels, pulse lcd_line_start with a pixel -> that pixel goes to
//      address 0x000. 255 more pixels fill bank 0, and line_ready asserts only after
//      those.
//   5. Continuous streaming, writer and reader 1 pixel/cycle, reader one line behind
//      -> last-write and last-read coincide. Both banks change ownership, with no
//      lost or duplicated lines over 8 lines.
//   6. Assert reset_n=0 mid-read at rd_ptr=37 -> led_valid=0, led_line_ready=0,
//      lcd_ready=1 immediately. Pre-load overrun_count at 255, drop another pixel
//      -> it stays 255.

Source files
------------

// File: rtl/pixel_line_bank_ctrl_if.sv
// Bus bundle between the line bank controller, the LCD capture side, the LED
// row driver and the dual-port pixel RAM.
interface pixel_line_bank_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  lcd_line_start;
  logic                  lcd_valid;
  logic [DATA_WIDTH-1:0] lcd_data;
  logic                  lcd_ready;
  logic                  led_line_ready;
  logic                  led_rd_en;
  logic                  led_valid;
  logic [DATA_WIDTH-1:0] led_data;
  logic [CNT_WIDTH-1:0]  overrun_count;
  logic                  ram_we_a;
  logic [ADDR_WIDTH-1:0] ram_addr_a;
  logic [DATA_WIDTH-1:0] ram_data_a;
  logic [ADDR_WIDTH-1:0] ram_addr_b;
  logic [DATA_WIDTH-1:0] ram_q_b;

  // Environment side: LCD source, LED reader and the RAM read data.
  modport master (
    output lcd_line_start, lcd_valid, lcd_data, led_rd_en, ram_q_b,
    input  lcd_ready, led_line_ready, led_valid, led_data, overrun_count,
           ram_we_a, ram_addr_a, ram_data_a, ram_addr_b
  );

  // Controller side.
  modport slave (
    input  lcd_line_start, lcd_valid, lcd_data, led_rd_en, ram_q_b,
    output lcd_ready, led_line_ready, led_valid, led_data, overrun_count,
           ram_we_a, ram_addr_a, ram_data_a, ram_addr_b
  );
endinterface

// File: rtl/pixel_line_bank_ctrl.sv
// Ping-pong line scheduler: LCD pixels fill one RAM bank while the LED side
// drains the other; banks change hands only on whole-line boundaries.
module pixel_line_bank_ctrl #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned LINE_PIXELS = 256,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pixel_line_bank_ctrl_if.slave  bus
);

  localparam int unsigned PTR_WIDTH = ADDR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(LINE_PIXELS - 1);

  logic                 wr_bank, rd_bank;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [1:0]           full;
  logic                 led_valid_q;
  logic [CNT_WIDTH-1:0] overrun_q;

  logic                 wr_ready, wr_acc, wr_last, drop;
  logic                 rd_ready, rd_acc, rd_last;
  logic [PTR_WIDTH-1:0] wr_base, wr_ptr_nxt, rd_ptr_nxt;
  logic                 wr_bank_nxt, rd_bank_nxt;
  logic [1:0]           full_nxt;
  logic [CNT_WIDTH-1:0] overrun_nxt;

  // Next-state: line_start rebases the write pointer before the accept applies.
  always_comb begin
    wr_ready    = !full[wr_bank];
    wr_acc      = bus.lcd_valid & wr_ready;
    drop        = bus.lcd_valid & !wr_ready;
    wr_base     = bus.lcd_line_start ? '0 : wr_ptr;
    wr_last     = wr_acc && (wr_base == LAST_PTR);
    rd_ready    = full[rd_bank];
    rd_acc      = bus.led_rd_en & rd_ready;
    rd_last     = rd_acc && (rd_ptr == LAST_PTR);

    wr_ptr_nxt  = wr_base;
    wr_bank_nxt = wr_bank;
    rd_ptr_nxt  = rd_ptr;
    rd_bank_nxt = rd_bank;
    full_nxt    = full;
    overrun_nxt = overrun_q;

    if (wr_acc) begin
      wr_ptr_nxt  = wr_last ? '0 : wr_base + PTR_WIDTH'(1);
      wr_bank_nxt = wr_bank ^ wr_last;
    end
    if (rd_acc) begin
      rd_ptr_nxt  = rd_last ? '0 : rd_ptr + PTR_WIDTH'(1);
      rd_bank_nxt = rd_bank ^ rd_last;
    end
    // Writer and reader finishing together always hit opposite banks.
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    if (drop && (overrun_q != '1)) overrun_nxt = overrun_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      full        <= '0;
      led_valid_q <= 1'b0;
      overrun_q   <= '0;
    end else begin
      wr_bank     <= wr_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      full        <= full_nxt;
      led_valid_q <= rd_acc;
      overrun_q   <= overrun_nxt;
    end
  end

  assign bus.lcd_ready      = wr_ready;
  assign bus.led_line_ready = rd_ready;
  assign bus.led_valid      = led_valid_q;
  assign bus.led_data       = bus.ram_q_b;
  assign bus.overrun_count  = overrun_q;
  assign bus.ram_we_a       = wr_acc;
  assign bus.ram_addr_a     = {wr_bank, wr_base};
  assign bus.ram_data_a     = bus.lcd_data;
  assign bus.ram_addr_b     = {rd_bank, rd_ptr};

endmodule
